// File: rtl/qed_dup_queue.sv
// SQED original/duplicate sequencer placed between fetch and the decoder.
// ORIG phase forwards fetched instructions and queues the qualifying ones;
// DUP phase replays the queue with registers remapped to x16-x31 and memory
// offsets shifted so the duplicate stream touches a disjoint address range.
module qed_dup_queue #(
    parameter int          DEPTH      = 16,
    parameter int          PTR_W      = 4,
    parameter logic [11:0] MEM_OFFSET = 12'd512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic [31:0]      inst_in,
    input  logic             inst_in_valid,
    output logic             inst_in_ready,
    input  logic             stall,
    input  logic             exec_dup,
    output logic [31:0]      inst_out,
    output logic             inst_out_valid,
    output logic             dup_mode,
    output logic             dup_done,
    output logic [PTR_W:0]   count
);

    localparam logic [6:0]   OP_R    = 7'b0110011;
    localparam logic [6:0]   OP_I    = 7'b0010011;
    localparam logic [6:0]   OP_LOAD = 7'b0000011;
    localparam logic [6:0]   OP_STORE= 7'b0100011;
    localparam logic [2:0]   F3_WORD = 3'b010;
    localparam logic [31:0]  NOP     = 32'h00000013;
    localparam logic [PTR_W:0] FULL  = (PTR_W+1)'(DEPTH);

    typedef enum logic {ST_ORIG, ST_DUP} state_t;

    state_t            r_state, w_state_next;
    logic [PTR_W-1:0]  r_wr_ptr, w_wr_ptr_next;
    logic [PTR_W-1:0]  r_rd_ptr, w_rd_ptr_next;
    logic [PTR_W:0]    r_count, w_count_next;
    logic [31:0]       r_out, w_out_next;
    logic              r_valid, w_valid_next;
    logic              r_done, w_done_next;
    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_push;

    // Only instructions whose register fields all sit in x0-x15 can be
    // duplicated without colliding with the duplicate register bank.
    function automatic logic f_qualify(input logic [31:0] i);
        logic q;
        q = 1'b0;
        case (i[6:0])
            OP_R:     q = !i[11] && !i[19] && !i[24];
            OP_I:     q = !i[11] && !i[19];
            OP_LOAD:  q = (i[14:12] == F3_WORD) && !i[11] && !i[19];
            OP_STORE: q = (i[14:12] == F3_WORD) && !i[19] && !i[24];
            default:  q = 1'b0;
        endcase
        return q;
    endfunction

    function automatic logic [4:0] f_map(input logic [4:0] r);
        return (r == 5'd0) ? 5'd0 : {1'b1, r[3:0]};
    endfunction

    // Build the duplicate of a queued (hence qualifying) instruction.
    function automatic logic [31:0] f_transform(input logic [31:0] i);
        logic [31:0] t;
        logic [11:0] s_imm;
        t = i;
        s_imm = {i[31:25], i[11:7]} + MEM_OFFSET;
        case (i[6:0])
            OP_R: begin
                t[11:7]  = f_map(i[11:7]);
                t[19:15] = f_map(i[19:15]);
                t[24:20] = f_map(i[24:20]);
            end
            OP_I: begin
                t[11:7]  = f_map(i[11:7]);
                t[19:15] = f_map(i[19:15]);
            end
            OP_LOAD: begin
                t[11:7]  = f_map(i[11:7]);
                t[19:15] = f_map(i[19:15]);
                t[31:20] = i[31:20] + MEM_OFFSET;
            end
            OP_STORE: begin
                t[19:15] = f_map(i[19:15]);
                t[24:20] = f_map(i[24:20]);
                t[31:25] = s_imm[11:5];
                t[11:7]  = s_imm[4:0];
            end
            default: t = i;
        endcase
        return t;
    endfunction

    // With ena low every valid input is taken regardless of queue state.
    assign inst_in_ready = !stall && (!ena || (r_state == ST_ORIG && r_count < FULL));
    assign w_accept      = inst_in_valid && inst_in_ready;
    assign w_push        = ena && (r_state == ST_ORIG) && w_accept && f_qualify(inst_in);

    // Next-state, pointer, count and registered-output computation.
    always_comb begin
        w_state_next  = r_state;
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        w_out_next    = r_out;
        w_valid_next  = r_valid;
        w_done_next   = 1'b0;
        if (stall) begin
            w_done_next = 1'b0;
        end else if (!ena) begin
            w_state_next  = ST_ORIG;
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            w_count_next  = '0;
            w_valid_next  = inst_in_valid;
            if (inst_in_valid)
                w_out_next = inst_in;
        end else if (r_state == ST_ORIG) begin
            w_valid_next = w_accept;
            if (w_accept)
                w_out_next = inst_in;
            if (w_push) begin
                w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
                w_count_next  = r_count + (PTR_W+1)'(1);
            end
            if (w_count_next != '0 && (exec_dup || w_count_next == FULL))
                w_state_next = ST_DUP;
        end else begin
            w_out_next    = f_transform(r_mem[r_rd_ptr]);
            w_valid_next  = 1'b1;
            w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
            w_count_next  = r_count - (PTR_W+1)'(1);
            if (r_count == (PTR_W+1)'(1)) begin
                w_state_next = ST_ORIG;
                w_done_next  = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_ORIG;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_out    <= NOP;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_out    <= w_out_next;
            r_valid  <= w_valid_next;
            r_done   <= w_done_next;
        end
    end

    // Queue storage; no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= inst_in;
    end

    assign inst_out       = r_out;
    assign inst_out_valid = r_valid;
    assign dup_mode       = (r_state == ST_DUP);
    assign dup_done       = r_done;
    assign count          = r_count;

endmodule

// File: tb/tb_qed_dup_queue.sv
// Bench for qed_dup_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_qed_dup_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic [31:0] in_inst = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        stall = 1'b0;
    logic        exec = 1'b0;
    logic [31:0] inst_out;
    logic        out_valid;
    logic        dup_mode;
    logic        dup_done;
    logic [4:0]  count;

    int total = 0;
    int bad   = 0;

    qed_dup_queue dut (
        .clk(clk), .reset(rst), .ena(ena),
        .inst_in(in_inst), .inst_in_valid(in_valid), .inst_in_ready(in_ready),
        .stall(stall), .exec_dup(exec),
        .inst_out(inst_out), .inst_out_valid(out_valid),
        .dup_mode(dup_mode), .dup_done(dup_done), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] q[$];
    logic        m_dup = 1'b0;
    logic [31:0] m_out = 32'h13;
    logic        m_valid = 1'b0;
    logic        m_done = 1'b0;

    function automatic int mr(input int r);
        return (r == 0) ? 0 : r + 16;
    endfunction

    function automatic logic m_qual(input logic [31:0] x);
        int op, f3, rd, rs1, rs2;
        op = int'(x[6:0]); f3 = int'(x[14:12]);
        rd = int'(x[11:7]); rs1 = int'(x[19:15]); rs2 = int'(x[24:20]);
        if (op == 51) return rd < 16 && rs1 < 16 && rs2 < 16;
        if (op == 19) return rd < 16 && rs1 < 16;
        if (op == 3)  return f3 == 2 && rd < 16 && rs1 < 16;
        if (op == 35) return f3 == 2 && rs1 < 16 && rs2 < 16;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_xform(input logic [31:0] x);
        int op, rd, rs1, rs2, imm;
        logic [11:0] s;
        op = int'(x[6:0]);
        rd = int'(x[11:7]); rs1 = int'(x[19:15]); rs2 = int'(x[24:20]);
        case (op)
            51: return {x[31:25], 5'(mr(rs2)), 5'(mr(rs1)), x[14:12], 5'(mr(rd)), x[6:0]};
            19: return {x[31:20], 5'(mr(rs1)), x[14:12], 5'(mr(rd)), x[6:0]};
            3: begin
                imm = int'(x[31:20]);
                s = 12'((imm + 512) % 4096);
                return {s, 5'(mr(rs1)), x[14:12], 5'(mr(rd)), x[6:0]};
            end
            default: begin
                imm = int'(x[31:25]) * 32 + int'(x[11:7]);
                s = 12'((imm + 512) % 4096);
                return {s[11:5], 5'(mr(rs2)), 5'(mr(rs1)), x[14:12], s[4:0], x[6:0]};
            end
        endcase
    endfunction

    // Advance the model on each edge, then compare the DUT just after it.
    always @(posedge clk) begin
        logic m_ready;
        if (rst) begin
            q.delete(); m_dup = 1'b0; m_out = 32'h13; m_valid = 1'b0; m_done = 1'b0;
        end else if (stall) begin
            m_done = 1'b0;
        end else if (!ena) begin
            q.delete(); m_dup = 1'b0; m_done = 1'b0;
            m_valid = in_valid;
            if (in_valid) m_out = in_inst;
        end else if (m_dup) begin
            m_out = m_xform(q.pop_front());
            m_valid = 1'b1;
            m_done = (q.size() == 0);
            if (q.size() == 0) m_dup = 1'b0;
        end else begin
            m_done = 1'b0;
            m_valid = in_valid && q.size() < 16;
            if (m_valid) begin
                m_out = in_inst;
                if (m_qual(in_inst)) q.push_back(in_inst);
            end
            if (q.size() > 0 && (exec || q.size() == 16)) m_dup = 1'b1;
        end
        #1;
        m_ready = !stall && (!ena || (!m_dup && q.size() < 16));
        chk("m_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) chk("m_inst_out", inst_out, m_out);
        chk("m_dup_mode", 32'(dup_mode), 32'(m_dup));
        chk("m_dup_done", 32'(dup_done), 32'(m_done));
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_ready", 32'(in_ready), 32'(m_ready));
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic x);
        in_valid = v; in_inst = i; exec = x;
        tick();
    endtask

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    initial begin
        tick(); tick();
        chk("rst_inst_out", inst_out, 32'h00000013);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        rst = 1'b0;
        tick();

        // add x3,x1,x2 then duplicate
        drive(1'b1, 32'h002081B3, 1'b1);
        chk("add_dup_mode", 32'(dup_mode), 32'h1);
        drive(1'b0, 32'h0, 1'b0);
        chk("add_dup_inst", inst_out, 32'h012889B3);
        chk("add_dup_done", 32'(dup_done), 32'h1);
        chk("add_count", 32'(count), 32'h0);

        // lw x5,8(x0)
        drive(1'b1, 32'h00802283, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        chk("lw_dup_inst", inst_out, 32'h20802A83);

        // add x20,x0,x0 is not queued, exec_dup ignored
        drive(1'b1, 32'h00000A33, 1'b1);
        chk("nq_inst", inst_out, 32'h00000A33);
        chk("nq_valid", 32'(out_valid), 32'h1);
        chk("nq_count", 32'(count), 32'h0);
        chk("nq_dup_mode", 32'(dup_mode), 32'h0);
        drive(1'b0, 32'h0, 1'b0);

        // fill the queue to DEPTH without exec_dup
        for (int i = 0; i < 16; i++) drive(1'b1, addi((i % 15) + 1, i, i), 1'b0);
        chk("full_ready", 32'(in_ready), 32'h0);
        chk("full_dup_mode", 32'(dup_mode), 32'h1);
        drive(1'b0, 32'h0, 1'b0);
        chk("full_first_dup", inst_out, 32'h00000893);
        for (int i = 1; i < 16; i++) tick();
        chk("full_done", 32'(dup_done), 32'h1);
        chk("full_ready_back", 32'(in_ready), 32'h1);
        chk("full_count", 32'(count), 32'h0);

        // mixed stream with non-qualifying entries, then stall mid-DUP
        drive(1'b1, 32'h002081B3, 1'b0);   // add x3,x1,x2
        drive(1'b1, 32'h00312223, 1'b0);   // sw x3,4(x2)
        drive(1'b1, 32'h00208063, 1'b0);   // beq (not queued)
        drive(1'b1, 32'hF0012083, 1'b0);   // lw x1,-256(x2)
        drive(1'b1, 32'h011081B3, 1'b0);   // add x3,x1,x17 (not queued)
        drive(1'b1, 32'h00500093, 1'b0);   // addi x1,x0,5
        drive(1'b1, 32'h40208133, 1'b1);   // sub x2,x1,x2 + exec_dup
        chk("mix_count", 32'(count), 32'h5);
        drive(1'b0, 32'h0, 1'b0);
        chk("mix_count4", 32'(count), 32'h4);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_count", 32'(count), 32'h4);
            chk("stall_inst", inst_out, 32'h012889B3);
        end
        stall = 1'b0;
        tick();
        chk("sw_dup_inst", inst_out, 32'h21392223);
        tick();
        chk("lw_wrap_inst", inst_out, 32'h10092883);
        tick(); tick();
        chk("mix_done", 32'(dup_done), 32'h1);

        // async reset mid-DUP with five entries left
        for (int i = 0; i < 6; i++) drive(1'b1, addi(i + 1, i, 3 * i), i == 5);
        drive(1'b0, 32'h0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'h5);
        rst = 1'b1;
        tick();
        chk("midrst_inst", inst_out, 32'h00000013);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_dup", 32'(dup_mode), 32'h0);
        chk("midrst_count", 32'(count), 32'h0);
        rst = 1'b0;
        tick();

        // ena dropped mid-DUP discards the queue and passes input through
        for (int i = 0; i < 3; i++) drive(1'b1, addi(i + 2, i + 1, i), i == 2);
        drive(1'b0, 32'h0, 1'b0);
        ena = 1'b0;
        drive(1'b1, 32'h00208063, 1'b0);
        chk("ena0_inst", inst_out, 32'h00208063);
        chk("ena0_count", 32'(count), 32'h0);
        chk("ena0_dup", 32'(dup_mode), 32'h0);
        drive(1'b1, 32'h002081B3, 1'b1);
        chk("ena0_noq", 32'(count), 32'h0);
        ena = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
